mode_sequencer: RTL and testbench
=================================

MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 The block SHALL have parameter ALARM_MS, default 5000, meaning the alarm duration in 1 kHz ticks.
REQ-002 The block SHALL have parameter BLINK_MS, default 250, meaning the alarm blink half-period in 1 kHz ticks.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port khz_tick, input, 1 bit: one-clk-wide pulse, one per millisecond.
REQ-006 The block SHALL have port select_btn, input, 1 bit: debounced select button level.
REQ-007 The block SHALL have port toggle_btn, input, 1 bit: debounced start/stop button level.
REQ-008 The block SHALL have port add_one_btn, input, 1 bit: debounced +1 button level.
REQ-009 The block SHALL have port add_ten_btn, input, 1 bit: debounced +10 button level.
REQ-010 The block SHALL have port timer_done, input, 1 bit: high while the countdown timer reads zero after running.
REQ-011 The block SHALL have port select, output, 2 bits: display mux select (0 = 12 h clock, 1 = 24 h clock, 2 = timer, 3 = stopwatch).
REQ-012 The block SHALL have port timer_toggle, output, 1 bit: one-clk start/stop pulse to the timer.
REQ-013 The block SHALL have port timer_add_one, output, 1 bit: one-clk +1 pulse to the timer.
REQ-014 The block SHALL have port timer_add_ten, output, 1 bit: one-clk +10 pulse to the timer.
REQ-015 The block SHALL have port sw_toggle, output, 1 bit: one-clk start/stop pulse to the stopwatch.
REQ-016 The block SHALL have port alarm, output, 1 bit: high while in state ALARM.
REQ-017 The block SHALL have port blink, output, 1 bit: display blank strobe, toggling during ALARM and 0 otherwise.

Function
REQ-018 Each button input SHALL have a registered rising-edge detector producing a one-clk edge pulse; a held button SHALL produce exactly one pulse.
REQ-019 The FSM SHALL have states CLK12, CLK24, TIMER, SWATCH and ALARM, with select = 0, 1, 2, 3 and 2 respectively.
REQ-020 A select edge SHALL advance CLK12->CLK24->TIMER->SWATCH->CLK12, with select updating one clk after the edge pulse.
REQ-021 A timer_done rising edge SHALL move any non-ALARM state to ALARM on the next clk; this SHALL take priority over a same-cycle select edge.
REQ-022 In TIMER, toggle, add_one and add_ten edges SHALL drive timer_toggle, timer_add_one and timer_add_ten respectively, each as a one-clk pulse registered one clk after the edge.
REQ-023 In SWATCH, a toggle edge SHALL drive sw_toggle; add_one and add_ten edges SHALL be discarded.
REQ-024 In CLK12 and CLK24, all non-select button edges SHALL be discarded.
REQ-025 A select edge in the same cycle as any other button edge SHALL be acted on, and the other edge SHALL be dropped: no output pulse.
REQ-026 On entering ALARM, a duration counter SHALL clear, then increment on each khz_tick.
REQ-027 ALARM SHALL exit to TIMER when the duration counter reaches ALARM_MS-1 on a khz_tick, or on any button edge, whichever comes first.
REQ-028 A button edge that acknowledges ALARM SHALL generate no timer_*, sw_toggle or mode advance.
REQ-029 In ALARM, blink SHALL start at 1 and invert every BLINK_MS khz_ticks, using a separate counter that wraps to 0.
REQ-030 A timer_done edge while in ALARM SHALL be ignored, and the counters SHALL NOT restart.
REQ-031 Counter widths SHALL hold ALARM_MS-1 and BLINK_MS-1 without overflow.
REQ-032 At most one output pulse SHALL be high in any clk.

Reset
REQ-033 While reset is high, the block SHALL be in state CLK12 with select = 0, all pulse outputs = 0, alarm = 0, blink = 0, counters = 0, and edge-detector history registers = 0.
REQ-034 A reset asserted mid-ALARM or mid-pulse SHALL abort it immediately and asynchronously.
REQ-035 After reset release, a button already held high SHALL produce one edge.

Verification
REQ-036 Reset, then 4 select presses -> select sequence 1, 2, 3, 0, each change occurring one clk after the press edge.
REQ-037 In TIMER, press add_ten and hold for 100 clk -> exactly one timer_add_ten pulse; timer_toggle, timer_add_one and sw_toggle stay 0.
REQ-038 In SWATCH, press add_one then toggle -> no timer pulses and exactly one sw_toggle pulse; in CLK24, press toggle -> no pulses.
REQ-039 In CLK12, raise timer_done and apply 5000 khz_ticks -> alarm=1 and select=2 for 5000 ticks, blink toggles every 250 ticks (20 transitions), then state TIMER with alarm=0 and blink=0.
REQ-040 In ALARM after 1000 ticks, press toggle -> TIMER next clk with no timer_toggle pulse; assert reset during a later ALARM -> immediate CLK12 with alarm=0.
REQ-041 Press select and toggle in the same clk while in TIMER -> SWATCH with no timer_toggle and no sw_toggle.

Source files
------------

// File: rtl/mode_sequencer.sv
// mode_sequencer: top-level mode FSM for a clock / timer / stopwatch display.
//
// Buttons are edge-detected against a registered history. A select edge cycles the display
// mode CLK12 -> CLK24 -> TIMER -> SWATCH -> CLK12. Other button edges become one-clk command
// pulses to the timer (in TIMER) or the stopwatch (in SWATCH); they are discarded in the
// clock modes. A rising timer_done enters ALARM. ALARM lasts ALARM_MS khz ticks, or ends
// earlier when any button is pressed, and then returns to TIMER. While in ALARM, blink
// toggles every BLINK_MS ticks.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   khz_tick      one-clk pulse per millisecond
//   select_btn    debounced select level
//   toggle_btn    debounced start/stop level
//   add_one_btn   debounced +1 level
//   add_ten_btn   debounced +10 level
//   timer_done    high while the countdown reads zero after running
//   select        display mux select (0 = 12 h, 1 = 24 h, 2 = timer, 3 = stopwatch)
//   timer_toggle  one-clk start/stop pulse to the timer
//   timer_add_one one-clk +1 pulse to the timer
//   timer_add_ten one-clk +10 pulse to the timer
//   sw_toggle     one-clk start/stop pulse to the stopwatch
//   alarm         high while in ALARM
//   blink         display blank strobe, toggling in ALARM, 0 otherwise
module mode_sequencer #(
  parameter int unsigned ALARM_MS = 5000,
  parameter int unsigned BLINK_MS = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       khz_tick,
  input  logic       select_btn,
  input  logic       toggle_btn,
  input  logic       add_one_btn,
  input  logic       add_ten_btn,
  input  logic       timer_done,
  output logic [1:0] select,
  output logic       timer_toggle,
  output logic       timer_add_one,
  output logic       timer_add_ten,
  output logic       sw_toggle,
  output logic       alarm,
  output logic       blink
);

  localparam int unsigned AlarmW = (ALARM_MS > 1) ? $clog2(ALARM_MS) : 1;
  localparam int unsigned BlinkW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [AlarmW-1:0] AlarmLast = AlarmW'(ALARM_MS - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_MS - 1);

  typedef enum logic [2:0] {
    StClk12,
    StClk24,
    StTimer,
    StSwatch,
    StAlarm
  } state_e;

  // Button vector bit order: [3] select, [2] toggle, [1] add_one, [0] add_ten.
  // Pulse vector bit order:  [3] timer_toggle, [2] timer_add_one, [1] timer_add_ten,
  //                          [0] sw_toggle.
  logic [3:0]        btn;
  logic [3:0]        btn_q;
  logic [3:0]        btn_edge;
  logic              done_q;
  logic              done_edge;
  state_e            state_q, state_d;
  logic [3:0]        pulse_q, pulse_d;
  logic [AlarmW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;

  assign btn       = {select_btn, toggle_btn, add_one_btn, add_ten_btn};
  assign btn_edge  = btn & ~btn_q;
  assign done_edge = timer_done & ~done_q;

  always_comb begin
    state_d     = state_q;
    pulse_d     = '0;
    // Counters and blink stay cleared outside ALARM, so entering ALARM always starts fresh.
    alarm_cnt_d = '0;
    blink_cnt_d = '0;
    blink_d     = 1'b0;

    if (state_q == StAlarm) begin
      // Any button press only acknowledges the alarm. It produces no command pulse and no
      // mode advance. timer_done is ignored here.
      if (|btn_edge) begin
        state_d = StTimer;
      end else begin
        alarm_cnt_d = alarm_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (khz_tick) begin
          if (alarm_cnt_q == AlarmLast) begin
            state_d     = StTimer;
            alarm_cnt_d = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b0;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 1'b1;
            if (blink_cnt_q == BlinkLast) begin
              blink_cnt_d = '0;
              blink_d     = ~blink_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 1'b1;
            end
          end
        end
      end
    end else if (done_edge) begin
      // Entering ALARM takes priority over every button edge in the same cycle.
      state_d = StAlarm;
      blink_d = 1'b1;
    end else if (btn_edge[3]) begin
      // A select edge wins, and other edges in the same cycle are dropped.
      unique case (state_q)
        StClk12: state_d = StClk24;
        StClk24: state_d = StTimer;
        StTimer: state_d = StSwatch;
        default: state_d = StClk12;
      endcase
    end else if (state_q == StTimer) begin
      // If several edges arrive together, only one pulse is sent: toggle > add_one > add_ten.
      if (btn_edge[2]) begin
        pulse_d[3] = 1'b1;
      end else if (btn_edge[1]) begin
        pulse_d[2] = 1'b1;
      end else if (btn_edge[0]) begin
        pulse_d[1] = 1'b1;
      end
    end else if (state_q == StSwatch) begin
      pulse_d[0] = btn_edge[2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StClk12;
      btn_q       <= '0;
      done_q      <= 1'b0;
      pulse_q     <= '0;
      alarm_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn;
      done_q      <= timer_done;
      pulse_q     <= pulse_d;
      alarm_cnt_q <= alarm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  always_comb begin
    select = 2'd0;
    unique case (state_q)
      StClk12:  select = 2'd0;
      StClk24:  select = 2'd1;
      StTimer:  select = 2'd2;
      StSwatch: select = 2'd3;
      StAlarm:  select = 2'd2;
      default:  select = 2'd0;
    endcase
  end

  assign timer_toggle  = pulse_q[3];
  assign timer_add_one = pulse_q[2];
  assign timer_add_ten = pulse_q[1];
  assign sw_toggle     = pulse_q[0];
  assign alarm         = (state_q == StAlarm);
  assign blink         = blink_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer. It applies a hand-written vector table, directed multi-cycle
// sequences, and random button activity. Every cycle is compared against a behavioural model
// that tracks the mode, the elapsed alarm ticks and the last command.
module tb_mode_sequencer;

  localparam int ALARM_MS = 5000;
  localparam int BLINK_MS = 250;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       khz_tick = 1'b0;
  logic       select_btn = 1'b0;
  logic       toggle_btn = 1'b0;
  logic       add_one_btn = 1'b0;
  logic       add_ten_btn = 1'b0;
  logic       timer_done = 1'b0;
  logic [1:0] select;
  logic       timer_toggle;
  logic       timer_add_one;
  logic       timer_add_ten;
  logic       sw_toggle;
  logic       alarm;
  logic       blink;

  mode_sequencer #(
    .ALARM_MS(ALARM_MS),
    .BLINK_MS(BLINK_MS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .khz_tick     (khz_tick),
    .select_btn   (select_btn),
    .toggle_btn   (toggle_btn),
    .add_one_btn  (add_one_btn),
    .add_ten_btn  (add_ten_btn),
    .timer_done   (timer_done),
    .select       (select),
    .timer_toggle (timer_toggle),
    .timer_add_one(timer_add_one),
    .timer_add_ten(timer_add_ten),
    .sw_toggle    (sw_toggle),
    .alarm        (alarm),
    .blink        (blink)
  );

  always #5 clk = ~clk;

  // Observed vector: {select[1:0], timer_toggle, timer_add_one, timer_add_ten, sw_toggle,
  //                   alarm, blink}
  logic [7:0] dut_out;
  assign dut_out = {select, timer_toggle, timer_add_one, timer_add_ten, sw_toggle, alarm, blink};

  // Input word: {select, toggle, add_one, add_ten, timer_done}
  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_SEL  = 5'b10000;
  localparam logic [4:0] I_TOG  = 5'b01000;
  localparam logic [4:0] I_ONE  = 5'b00100;
  localparam logic [4:0] I_TEN  = 5'b00010;
  localparam logic [4:0] I_DONE = 5'b00001;

  int n_checks = 0;
  int n_fail = 0;
  int cnt_tt, cnt_a1, cnt_a10, cnt_sw;

  // Behavioural model. Modes 0..3 are the display modes, and 4 is the alarm.
  int         m_mode;
  int         m_ticks;
  int         m_pulse;  // -1 none, 0 timer_toggle, 1 add_one, 2 add_ten, 3 sw_toggle
  logic [4:0] m_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode  = 0;
    m_ticks = 0;
    m_pulse = -1;
    m_prev  = '0;
  endfunction

  function automatic void model_clock(input logic [4:0] in, input logic tick);
    logic [4:0] e;
    e = in & ~m_prev;
    m_pulse = -1;
    if (m_mode == 4) begin
      if (|e[4:1]) begin
        m_mode  = 2;
        m_ticks = 0;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == ALARM_MS) begin
          m_mode  = 2;
          m_ticks = 0;
        end
      end
    end else if (e[0]) begin
      m_mode  = 4;
      m_ticks = 0;
    end else if (e[4]) begin
      m_mode = (m_mode + 1) % 4;
    end else if (m_mode == 2) begin
      if (e[3]) m_pulse = 0;
      else if (e[2]) m_pulse = 1;
      else if (e[1]) m_pulse = 2;
    end else if (m_mode == 3 && e[3]) begin
      m_pulse = 3;
    end
    m_prev = in;
  endfunction

  function automatic logic [7:0] model_out();
    logic [3:0] p;
    logic [1:0] s;
    logic       b;
    p = 4'b1000;
    p = (m_pulse >= 0) ? (p >> m_pulse) : 4'b0000;
    s = (m_mode == 4) ? 2'd2 : 2'(m_mode);
    b = (m_mode == 4) && (((m_ticks / BLINK_MS) % 2) == 0);
    return {s, p, (m_mode == 4), b};
  endfunction

  // Drive one cycle of inputs, clock it, then compare against the model just after the edge.
  task automatic step(input logic [4:0] in, input logic tick);
    {select_btn, toggle_btn, add_one_btn, add_ten_btn, timer_done} = in;
    khz_tick = tick;
    @(posedge clk);
    model_clock(in, tick);
    #1;
    check("model", 32'(dut_out), 32'(model_out()));
    cnt_tt  += int'(timer_toggle);
    cnt_a1  += int'(timer_add_one);
    cnt_a10 += int'(timer_add_ten);
    cnt_sw  += int'(sw_toggle);
  endtask

  task automatic clear_counts();
    cnt_tt  = 0;
    cnt_a1  = 0;
    cnt_a10 = 0;
    cnt_sw  = 0;
  endtask

  task automatic do_reset(input logic [4:0] in);
    {select_btn, toggle_btn, add_one_btn, add_ten_btn, timer_done} = in;
    khz_tick = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(dut_out), 32'h0);
    model_reset();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [4:0] in;
    logic       tick;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int alarm_hi;
    int trans;
    logic prev_b;
    logic [4:0] lvl;
    logic [1:0] exp_sel[4];

    clear_counts();
    model_reset();

    // Vector table, applied from reset.
    vecs[0]  = '{I_NONE, 1'b0, 8'h00};
    vecs[1]  = '{I_SEL, 1'b0, 8'h40};
    vecs[2]  = '{I_NONE, 1'b0, 8'h40};
    vecs[3]  = '{I_TOG, 1'b0, 8'h40};          // CLK24: toggle discarded
    vecs[4]  = '{I_NONE, 1'b0, 8'h40};
    vecs[5]  = '{I_SEL, 1'b0, 8'h80};
    vecs[6]  = '{I_NONE, 1'b0, 8'h80};
    vecs[7]  = '{I_TEN, 1'b0, 8'h88};          // TIMER: add_ten pulse
    vecs[8]  = '{I_TEN, 1'b0, 8'h80};          // held: no repeat
    vecs[9]  = '{I_TOG, 1'b0, 8'hA0};          // timer_toggle
    vecs[10] = '{I_ONE, 1'b0, 8'h90};          // timer_add_one
    vecs[11] = '{I_SEL | I_TOG, 1'b0, 8'hC0};  // select wins, toggle dropped
    vecs[12] = '{I_NONE, 1'b0, 8'hC0};
    vecs[13] = '{I_ONE, 1'b0, 8'hC0};          // SWATCH: add_one discarded
    vecs[14] = '{I_TOG, 1'b0, 8'hC4};          // sw_toggle
    vecs[15] = '{I_DONE, 1'b0, 8'h83};         // enter ALARM, blink starts at 1
    vecs[16] = '{I_NONE, 1'b1, 8'h83};
    vecs[17] = '{I_TOG, 1'b0, 8'h80};          // acknowledge: TIMER, no pulse
    vecs[18] = '{I_NONE, 1'b0, 8'h80};
    vecs[19] = '{I_SEL | I_DONE, 1'b0, 8'h83}; // done beats select
    vecs[20] = '{I_NONE, 1'b0, 8'h83};
    vecs[21] = '{I_TEN, 1'b0, 8'h80};

    do_reset(I_NONE);
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].in, vecs[i].tick);
      check($sformatf("vec%0d", i), 32'(dut_out), 32'(vecs[i].exp));
    end

    // A button held through reset produces exactly one edge after release.
    do_reset(I_SEL);
    step(I_SEL, 1'b0);
    check("held_after_reset", 32'(select), 32'd1);
    step(I_SEL, 1'b0);
    check("held_after_reset_once", 32'(select), 32'd1);

    // Four select presses give the mode sequence 1, 2, 3, 0.
    do_reset(I_NONE);
    exp_sel[0] = 2'd1;
    exp_sel[1] = 2'd2;
    exp_sel[2] = 2'd3;
    exp_sel[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      step(I_SEL, 1'b0);
      check($sformatf("select_seq%0d", i), 32'(select), 32'(exp_sel[i]));
      step(I_NONE, 1'b0);
    end

    // In TIMER, hold add_ten for 100 clk.
    step(I_SEL, 1'b0);
    step(I_NONE, 1'b0);
    step(I_SEL, 1'b0);
    step(I_NONE, 1'b0);
    clear_counts();
    for (int i = 0; i < 100; i++) step(I_TEN, 1'b0);
    check("hold_ten_pulses", 32'(cnt_a10), 32'd1);
    check("hold_ten_others", 32'(cnt_tt + cnt_a1 + cnt_sw), 32'd0);

    // In SWATCH, add_one then toggle. Then in CLK24, toggle.
    step(I_SEL, 1'b0);
    step(I_NONE, 1'b0);
    clear_counts();
    step(I_ONE, 1'b0);
    step(I_NONE, 1'b0);
    step(I_TOG, 1'b0);
    step(I_NONE, 1'b0);
    check("swatch_timer_pulses", 32'(cnt_tt + cnt_a1 + cnt_a10), 32'd0);
    check("swatch_sw_pulses", 32'(cnt_sw), 32'd1);
    step(I_SEL, 1'b0);
    step(I_NONE, 1'b0);
    step(I_SEL, 1'b0);
    step(I_NONE, 1'b0);
    check("in_clk24", 32'(select), 32'd1);
    clear_counts();
    step(I_TOG, 1'b0);
    step(I_NONE, 1'b0);
    check("clk24_pulses", 32'(cnt_tt + cnt_a1 + cnt_a10 + cnt_sw), 32'd0);

    // Full-length alarm from CLK12 with a tick every clk.
    do_reset(I_NONE);
    alarm_hi = 0;
    trans = 0;
    prev_b = 1'b0;
    step(I_DONE, 1'b0);
    alarm_hi += int'(alarm);
    if (blink !== prev_b) trans++;
    prev_b = blink;
    for (int i = 0; i < ALARM_MS; i++) begin
      step(I_DONE, 1'b1);
      alarm_hi += int'(alarm);
      if (blink !== prev_b) trans++;
      prev_b = blink;
    end
    check("alarm_duration", 32'(alarm_hi), 32'(ALARM_MS));
    check("blink_transitions", 32'(trans), 32'(2 * (ALARM_MS / BLINK_MS) / 2));
    check("alarm_exit_state", 32'(dut_out), 32'h80);

    // Acknowledge after 1000 ticks, then reset asynchronously during a later alarm.
    step(I_NONE, 1'b0);
    step(I_DONE, 1'b0);
    for (int i = 0; i < 1000; i++) step(I_DONE, 1'b1);
    check("alarm_at_1000", 32'(alarm), 32'd1);
    clear_counts();
    step(I_DONE | I_TOG, 1'b0);
    check("ack_state", 32'(dut_out), 32'h80);
    check("ack_no_pulse", 32'(cnt_tt + cnt_a1 + cnt_a10 + cnt_sw), 32'd0);
    step(I_NONE, 1'b0);
    step(I_DONE, 1'b0);
    for (int i = 0; i < 300; i++) step(I_DONE, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", 32'(dut_out), 32'h0);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // Random button activity with a random tick pattern.
    lvl = '0;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 1; b < 5; b++) if ($urandom_range(0, 5) == 0) lvl[b] = ~lvl[b];
      if ($urandom_range(0, 39) == 0) lvl[0] = ~lvl[0];
      step(lvl, 1'($urandom_range(0, 1)));
      if (timer_toggle + timer_add_one + timer_add_ten + sw_toggle > 1) begin
        check("one_hot_pulses", 32'(timer_toggle + timer_add_one + timer_add_ten + sw_toggle), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
